store_buffer: RTL and testbench

- Posted-write FIFO between the MIPS core's data-memory write port (memwrite, dataadr, writedata) and the data memory.
- Core stores retire in one cycle into the buffer. The buffer drains them in order to memory over a req/ack handshake, so memory may take several cycles per write.
- Word-address forwarding lets a load see a buffered store that has not yet been written to memory.

---
 rtl/store_buffer.sv | 114 +++++++++++
 tb/tb_store_buffer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the core data-memory write port and
// data memory. Core stores retire in one cycle into a DEPTH-entry circular
// buffer; entries drain in order over a req/ack handshake. Loads can look up
// buffered stores by word address (youngest match wins).
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   memwrite/dataadr/writedata   core store (one per cycle)
//   stall               buffer full, core must hold its store
//   rd_adr              load address for forwarding lookup
//   fwd_hit/fwd_data    youngest buffered match (data 0 on miss)
//   mem_req/mem_adr/mem_wdata/mem_ack   drain handshake to memory
//   count               occupied entries
//   overflow            sticky: store arrived while full
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     memwrite,
  input  logic [AW-1:0]            dataadr,
  input  logic [DW-1:0]            writedata,
  output logic                     stall,
  input  logic [AW-1:0]            rd_adr,
  output logic                     fwd_hit,
  output logic [DW-1:0]            fwd_data,
  output logic                     mem_req,
  output logic [AW-1:0]            mem_adr,
  output logic [DW-1:0]            mem_wdata,
  input  logic                     mem_ack,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]    adr_q  [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             full, empty, push, pop;
  logic [DEPTH-1:0] hit_vec;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  // Push is gated only by registered fullness; a same-cycle pop never frees
  // room for a store, so stall has no path from mem_ack.
  assign push  = memwrite & ~full;
  assign pop   = ~empty & mem_ack;

  assign stall     = full;
  assign mem_req   = ~empty;
  assign mem_adr   = adr_q[rd_ptr];
  assign mem_wdata = data_q[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      vld      <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr      <= wr_ptr + 1'b1;
        vld[wr_ptr] <= 1'b1;
      end
      // push and pop never hit the same slot: that needs empty (no pop) or
      // full (no push)
      if (pop) begin
        rd_ptr      <= rd_ptr + 1'b1;
        vld[rd_ptr] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (memwrite && full) overflow <= 1'b1;
    end
  end

  // Payload needs no reset; vld gates every use of it.
  always_ff @(posedge clk) begin
    if (push) begin
      adr_q[wr_ptr]  <= dataadr;
      data_q[wr_ptr] <= writedata;
    end
  end

  // Per-entry word-address match
  for (genvar g = 0; g < DEPTH; g++) begin : g_match
    assign hit_vec[g] = vld[g] && (adr_q[g][AW-1:2] == rd_adr[AW-1:2]);
  end

  // Walk oldest to youngest starting at rd_ptr; later matches override, so the
  // entry closest to wr_ptr-1 wins. The head stays valid through its ack cycle.
  always_comb begin
    logic [PW-1:0] idx;
    idx      = '0;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (hit_vec[idx]) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          memwrite;
  logic [AW-1:0] dataadr;
  logic [DW-1:0] writedata;
  logic          stall;
  logic [AW-1:0] rd_adr;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic          mem_req;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [$clog2(DEPTH):0] count;
  logic          overflow;

  int n_chk = 0;
  int n_err = 0;

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .stall(stall), .rd_adr(rd_adr), .fwd_hit(fwd_hit),
    .fwd_data(fwd_data), .mem_req(mem_req), .mem_adr(mem_adr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one edge; inputs change and outputs are sampled 1ns after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d);
    memwrite = 1'b1; dataadr = a; writedata = d;
    step();
    memwrite = 1'b0;
  endtask

  logic [AW-1:0] exp_adr[$];
  logic [DW-1:0] exp_dat[$];

  initial begin
    reset = 1'b1; memwrite = 1'b0; dataadr = '0; writedata = '0;
    rd_adr = '0; mem_ack = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
    // reset / idle
    chk("rst_count", count, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_fwd_hit", fwd_hit, 0);
    chk("rst_fwd_data", fwd_data, 0);

    // single store with ack tied high: offered one cycle after push
    mem_ack = 1'b1;
    chk("ack_empty_req", mem_req, 0);
    store(84, 7);
    chk("s1_req", mem_req, 1);
    chk("s1_adr", mem_adr, 84);
    chk("s1_data", mem_wdata, 7);
    chk("s1_count", count, 1);
    step();
    chk("s1_pop_count", count, 0);
    chk("s1_pop_req", mem_req, 0);

    // fill, overflow, ordered drain
    mem_ack = 1'b0;
    for (int k = 0; k < 4; k++) store(80 + 4*k, k + 1);
    chk("full_count", count, 4);
    chk("full_stall", stall, 1);
    chk("full_ovf_pre", overflow, 0);
    store(20, 28);
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 4);
    mem_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_req", mem_req, 1);
      chk("drain_adr", mem_adr, 80 + 4*k);
      chk("drain_data", mem_wdata, k + 1);
      step();
    end
    chk("drain_count", count, 0);
    chk("drain_stall", stall, 0);
    chk("ovf_sticky", overflow, 1);

    // forwarding: duplicate address, youngest wins
    mem_ack = 1'b0;
    store(20, 5);
    store(20, 28);
    rd_adr = 20; #1;
    chk("fwd20_hit", fwd_hit, 1);
    chk("fwd20_data", fwd_data, 28);
    rd_adr = 23; #1;
    chk("fwd23_hit", fwd_hit, 1);
    chk("fwd23_data", fwd_data, 28);
    rd_adr = 24; #1;
    chk("fwd24_hit", fwd_hit, 0);
    chk("fwd24_data", fwd_data, 0);
    // a store presented this cycle is not forwarded
    memwrite = 1'b1; dataadr = 24; writedata = 99; #1;
    chk("fwd_samecyc_hit", fwd_hit, 0);
    memwrite = 1'b0;
    // head being acked still forwards (only entries are 20/5 and 20/28)
    mem_ack = 1'b1; rd_adr = 20; #1;
    chk("fwd_ack_hit", fwd_hit, 1);
    chk("fwd_ack_data", fwd_data, 28);
    chk("dup_head_data", mem_wdata, 5);
    step();
    chk("dup_next_data", mem_wdata, 28);
    step();
    chk("fwd_drained_count", count, 0);
    mem_ack = 1'b0;

    // steady push+pop with pointer wrap, scoreboarded order
    for (int k = 0; k < 2; k++) begin
      store(100 + 4*k, 100 + k);
      exp_adr.push_back(100 + 4*k); exp_dat.push_back(100 + k);
    end
    chk("wrap_pre_count", count, 2);
    mem_ack = 1'b1;
    for (int k = 0; k < 10; k++) begin
      memwrite = 1'b1; dataadr = 108 + 4*k; writedata = 102 + k; #1;
      chk("wrap_adr", mem_adr, exp_adr.pop_front());
      chk("wrap_data", mem_wdata, exp_dat.pop_front());
      exp_adr.push_back(dataadr); exp_dat.push_back(writedata);
      step();
      chk("wrap_count", count, 2);
    end
    memwrite = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("wrap_tail_adr", mem_adr, exp_adr.pop_front());
      chk("wrap_tail_data", mem_wdata, exp_dat.pop_front());
      step();
    end
    chk("wrap_end_count", count, 0);
    chk("wrap_end_req", mem_req, 0);

    // reset mid-drain, with an ack in the reset cycle
    mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) store(200 + 4*k, 50 + k);
    chk("mid_count", count, 3);
    chk("mid_req", mem_req, 1);
    reset = 1'b1; mem_ack = 1'b1;
    step();
    reset = 1'b0; mem_ack = 1'b0;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_req", mem_req, 0);
    chk("mid_rst_ovf", overflow, 0);
    rd_adr = 204; #1;
    chk("mid_rst_fwd", fwd_hit, 0);
    step();
    chk("mid_rst_no_reoffer", mem_req, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
